// File: rtl/nand_rd_data.sv
// nand_rd_data: NAND read-data cycle engine; issues Len REn strobes and
// captures DQ_in at each REn rise. Optional macro RB_WAIT_EN gates on RBn.
module nand_rd_data #(
    parameter int tRP_cnt  = 2,
    parameter int tREH_cnt = 1,
    parameter int LEN_W    = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Start,
    input  logic [LEN_W-1:0] Len,
    input  logic [7:0]       DQ_in,
    input  logic             RBn,
    output logic             REn,
    output logic             CLE,
    output logic             ALE,
    output logic [7:0]       Data_out,
    output logic             Data_valid,
    output logic             Busy,
    output logic             Over
);

    typedef enum logic [2:0] {
        IDLE,
        RE_LOW,
        RE_HIGH,
        OVER,
        WAIT_RB
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       phase_q;
    logic [LEN_W-1:0] byte_q;
    logic [LEN_W-1:0] len_q;
    logic             accept;
    logic             capture;
    logic             low_done;
    logic             high_done;
    logic             last_byte;

    assign accept    = (state_q == IDLE) && Start;
    assign capture   = (state_q == RE_LOW) && (state_d == RE_HIGH);
    assign low_done  = phase_q == 8'(tRP_cnt);
    assign high_done = phase_q == 8'(tREH_cnt);
    assign last_byte = byte_q == len_q;

`ifdef RB_WAIT_EN
    logic [1:0] rb_sync;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) rb_sync <= 2'b00;
        else       rb_sync <= {rb_sync[0], RBn};
    end
`else
    logic rb_unused;
    assign rb_unused = RBn;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
`ifdef RB_WAIT_EN
                    state_d = WAIT_RB;
`else
                    state_d = (Len == '0) ? OVER : RE_LOW;
`endif
                end
            end
            WAIT_RB: begin
`ifdef RB_WAIT_EN
                if (rb_sync[1])
                    state_d = (len_q == '0) ? OVER : RE_LOW;
`else
                state_d = IDLE;
`endif
            end
            RE_LOW: begin
                if (low_done) state_d = RE_HIGH;
            end
            RE_HIGH: begin
                if (high_done) state_d = last_byte ? OVER : RE_LOW;
            end
            OVER:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Phase counter restarts on every state change and saturates when idle
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            phase_q <= 8'd0;
            byte_q  <= '0;
            len_q   <= '0;
        end else begin
            if (state_d != state_q)  phase_q <= 8'd0;
            else if (phase_q != 8'hFE) phase_q <= phase_q + 8'd1;
            if (accept) begin
                len_q  <= Len;
                byte_q <= '0;
            end else if (capture) begin
                byte_q <= byte_q + 1'b1;
            end
        end
    end

    // Outputs follow the next state so they switch on the same edge
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            REn        <= 1'b1;
            Busy       <= 1'b0;
            Over       <= 1'b0;
            Data_valid <= 1'b0;
            Data_out   <= 8'h00;
        end else begin
            REn        <= state_d != RE_LOW;
            Busy       <= state_d != IDLE;
            Over       <= state_d == OVER;
            Data_valid <= capture;
            if (capture) Data_out <= DQ_in;
        end
    end

    assign CLE = 1'b0;
    assign ALE = 1'b0;

endmodule

// File: tb/tb_nand_rd_data.sv
// tb_nand_rd_data: randomized and directed bench for nand_rd_data with a
// timing-formula reference model checked on every clock.
module tb_nand_rd_data;

    localparam int TRP  = 2;
    localparam int TREH = 1;
    localparam int P    = TRP + TREH + 2;
`ifdef RB_WAIT_EN
    localparam int DW = 1;
`else
    localparam int DW = 0;
`endif

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        Start;
    logic [15:0] Len;
    logic [7:0]  DQ_in;
    logic        RBn;
    logic        REn;
    logic        CLE;
    logic        ALE;
    logic [7:0]  Data_out;
    logic        Data_valid;
    logic        Busy;
    logic        Over;

    int checks = 0;
    int errors = 0;

    // Model: start edge, length and pre-strobe delay of current transaction
    int         edge_n = 0;
    int         m_s    = -100000;
    int         m_len  = 0;
    int         m_d    = 0;
    logic [7:0] exp_dout = 8'h00;
    int         dv_cnt = 0;
    int         over_cnt = 0;

    nand_rd_data #(
        .tRP_cnt (TRP),
        .tREH_cnt(TREH),
        .LEN_W   (16)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Start     (Start),
        .Len       (Len),
        .DQ_in     (DQ_in),
        .RBn       (RBn),
        .REn       (REn),
        .CLE       (CLE),
        .ALE       (ALE),
        .Data_out  (Data_out),
        .Data_valid(Data_valid),
        .Busy      (Busy),
        .Over      (Over)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at edge %0d",
                   tag, obs, exp, edge_n);
        end
    endtask

    task automatic tick(input logic st, input logic [15:0] ln,
                        input logic [7:0] dq, input logic rb);
        int rel;
        int k;
        logic e_ren;
        logic e_busy;
        logic e_over;
        logic e_dv;
        @(negedge CLK);
        Start = st;
        Len   = ln;
        DQ_in = dq;
        RBn   = rb;
        @(posedge CLK);
        edge_n++;
        if (st && edge_n >= m_s + m_len * P + m_d + 2) begin
            m_s   = edge_n;
            m_len = int'(ln);
            m_d   = DW;
        end
        rel    = edge_n - m_s;
        k      = rel - m_d;
        e_ren  = !(k >= 0 && k < m_len * P && (k % P) < TRP + 1);
        e_dv   = k >= 0 && k < m_len * P && (k % P) == TRP + 1;
        e_busy = rel >= 0 && rel <= m_len * P + m_d;
        e_over = rel == m_len * P + m_d;
        if (e_dv) exp_dout = dq;
        #1;
        if (Data_valid === 1'b1) dv_cnt++;
        if (Over === 1'b1) over_cnt++;
        chk("REn", {15'd0, REn}, {15'd0, e_ren});
        chk("Busy", {15'd0, Busy}, {15'd0, e_busy});
        chk("Over", {15'd0, Over}, {15'd0, e_over});
        chk("Data_valid", {15'd0, Data_valid}, {15'd0, e_dv});
        chk("Data_out", {8'd0, Data_out}, {8'd0, exp_dout});
        chk("CLE_ALE", {14'd0, CLE, ALE}, 16'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_REn"}, {15'd0, REn}, 16'd1);
        chk({tag, "_Busy"}, {15'd0, Busy}, 16'd0);
        chk({tag, "_Over"}, {15'd0, Over}, 16'd0);
        chk({tag, "_Data_valid"}, {15'd0, Data_valid}, 16'd0);
        chk({tag, "_Data_out"}, {8'd0, Data_out}, 16'd0);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        #2 RSTn = 1'b0;
        #1 check_reset_vals("rst_async");
        m_s      = -100000;
        m_len    = 0;
        m_d      = 0;
        exp_dout = 8'h00;
        repeat (2) @(posedge CLK);
        #1 check_reset_vals("rst_held");
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (3) tick(1'b0, 16'd0, 8'h00, 1'b1);
    endtask

    initial begin
        int dv0;
        int ov0;
        RSTn  = 1'b0;
        Start = 1'b0;
        Len   = 16'd0;
        DQ_in = 8'h00;
        RBn   = 1'b1;
        repeat (2) @(posedge CLK);
        #1 check_reset_vals("por");
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (3) tick(1'b0, 16'd0, 8'h00, 1'b1);

        // single byte
        dv0 = dv_cnt;
        ov0 = over_cnt;
        tick(1'b1, 16'd1, 8'hA5, 1'b1);
        repeat (8) tick(1'b0, 16'd7, 8'hA5, 1'b1);
        chk("single_dout", {8'd0, Data_out}, 16'h00A5);
        chk("single_dv_count", 16'(dv_cnt - dv0), 16'd1);
        chk("single_over_count", 16'(over_cnt - ov0), 16'd1);

        // four-byte burst, DQ changes per low phase
        dv0 = dv_cnt;
        ov0 = over_cnt;
        for (int i = 0; i < 23; i++)
            tick(i == 0, 16'd4, 8'(8'h11 * (i / P + 1)), 1'b1);
        chk("burst_dout", {8'd0, Data_out}, 16'h0044);
        chk("burst_dv_count", 16'(dv_cnt - dv0), 16'd4);
        chk("burst_over_count", 16'(over_cnt - ov0), 16'd1);

        // zero length
        dv0 = dv_cnt;
        tick(1'b1, 16'd0, 8'h5A, 1'b1);
        repeat (4) tick(1'b0, 16'd0, 8'h5A, 1'b1);
        chk("len0_dv_count", 16'(dv_cnt - dv0), 16'd0);

        // start held high, Len churning while busy
        for (int i = 0; i < 80; i++)
            tick(1'b1, 16'($urandom_range(0, 5)), 8'($urandom), 1'b1);
        repeat (30) tick(1'b0, 16'd0, 8'($urandom), 1'b1);

        // random start pulses
        for (int i = 0; i < 500; i++)
            tick($urandom_range(0, 3) == 0, 16'($urandom_range(0, 6)),
                 8'($urandom), 1'b1);
        repeat (40) tick(1'b0, 16'd0, 8'($urandom), 1'b1);

        // reset in the middle of a burst
        tick(1'b1, 16'd5, 8'($urandom), 1'b1);
        repeat (9) tick(1'b0, 16'd0, 8'($urandom), 1'b1);
        apply_reset();
        for (int i = 0; i < 60; i++)
            tick($urandom_range(0, 2) == 0, 16'($urandom_range(0, 3)),
                 8'($urandom), 1'b1);
        repeat (20) tick(1'b0, 16'd0, 8'($urandom), 1'b1);

`ifdef RB_WAIT_EN
        // ready/busy held low for 20 cycles after Start
        repeat (3) tick(1'b0, 16'd0, 8'h00, 1'b0);
        tick(1'b1, 16'd2, 8'($urandom), 1'b0);
        m_d = 22;
        repeat (19) tick(1'b0, 16'd0, 8'($urandom), 1'b0);
        repeat (20) tick(1'b0, 16'd0, 8'($urandom), 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
